// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Issue control for an in-order pipeline. A per-register busy bit tracks
//   outstanding writes. The instruction in ID is stalled on RAW or WAW hazards
//   against those bits. A taken branch (resolved in MEM) squashes the younger
//   instructions: their busy bits are released through a short issue history,
//   and ID stays flushed for FLUSH_CYCLES cycles. A jump that issues flushes
//   ID for the following cycle.
//
// Optional feature (macro HAZARD_WB_BYPASS_EN):
//   When defined, a source register that is being written back in the same
//   cycle is treated as ready (WB-to-ID bypass). When undefined, that source
//   stalls for one more cycle, until its busy bit has cleared.
//
// Ports
//   clk_i, rst_i           clock; asynchronous active-high reset
//   id_valid_i             an instruction is present in ID
//   id_rs1_i/id_rs2_i      source register addresses
//   id_rs1_used_i/..rs2..  the instruction actually reads that source
//   id_rd_i, id_rd_we_i    destination register and its write enable
//   jump_i                 the ID instruction is a jump
//   branch_taken_i         a branch resolved taken in MEM this cycle
//   wb_we_i, wb_waddr_i    register file write from WB
//   issue_o                the ID instruction issues this cycle
//   stall_if_o/stall_id_o  hold IF and ID
//   flush_id_o/flush_ex_o  squash the ID / EX stage
//   busy_o                 pending-write bit per register (bit 0 is always 0)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  id_valid_i,
    input  logic                  id_rd_we_i,
    input  logic [ADDR_WIDTH-1:0] id_rs1_i,
    input  logic [ADDR_WIDTH-1:0] id_rs2_i,
    input  logic [ADDR_WIDTH-1:0] id_rd_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic                  jump_i,
    input  logic                  branch_taken_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
    output logic                  issue_o,
    output logic                  stall_if_o,
    output logic                  stall_id_o,
    output logic                  flush_id_o,
    output logic                  flush_ex_o,
    output logic [NUM_REGS-1:0]   busy_o
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    state_t                  state_q, state_n;
    logic [2:0]              count_q, count_n;
    logic                    jmp_flush_q;
    logic [NUM_REGS-1:0]     busy_q, busy_n;
    logic [FLUSH_CYCLES-1:0] hist_vld_q;
    logic [ADDR_WIDTH-1:0]   hist_rd_q [FLUSH_CYCLES];

    logic id_live;
    logic rs1_busy, rs2_busy, rd_busy;
    logic hazard;

    // The slot right after an issued jump holds a wrong-path instruction; it is
    // flushed, so it must neither issue nor raise a stall.
    assign id_live = id_valid_i & ~jmp_flush_q;

    always_comb begin
        rs1_busy = busy_q[id_rs1_i];
        rs2_busy = busy_q[id_rs2_i];
        rd_busy  = busy_q[id_rd_i];
`ifdef HAZARD_WB_BYPASS_EN
        if (wb_we_i && (wb_waddr_i == id_rs1_i)) rs1_busy = 1'b0;
        if (wb_we_i && (wb_waddr_i == id_rs2_i)) rs2_busy = 1'b0;
`endif
        hazard = id_live & ((id_rs1_used_i & rs1_busy) |
                            (id_rs2_used_i & rs2_busy) |
                            (id_rd_we_i    & rd_busy));
    end

    // Next state and outputs. Outputs are forced low while reset is held.
    always_comb begin
        state_n    = state_q;
        count_n    = count_q;
        issue_o    = 1'b0;
        stall_if_o = 1'b0;
        stall_id_o = 1'b0;
        flush_id_o = 1'b0;
        flush_ex_o = 1'b0;
        if (!rst_i) begin
            if (branch_taken_i) begin
                // Wins over hazards and jumps; also restarts an ongoing flush.
                flush_id_o = 1'b1;
                flush_ex_o = 1'b1;
                state_n    = FLUSH;
                count_n    = 3'(FLUSH_CYCLES - 1);
            end else begin
                case (state_q)
                    RUN, STALL: begin
                        flush_id_o = jmp_flush_q;
                        if (hazard) begin
                            stall_if_o = 1'b1;
                            stall_id_o = 1'b1;
                            state_n    = STALL;
                        end else begin
                            issue_o = id_live;
                            state_n = RUN;
                        end
                    end
                    FLUSH: begin
                        flush_id_o = 1'b1;
                        // The branch cycle itself was the first bubble, so the
                        // state is left as the count reaches zero.
                        if (count_q <= 3'd1) begin
                            count_n = 3'd0;
                            state_n = RUN;
                        end else begin
                            count_n = count_q - 3'd1;
                        end
                    end
                    default: state_n = RUN;
                endcase
            end
        end
    end

    // Busy update order matters: WB clear and branch release first, so that a
    // same-cycle issue to the same register leaves the bit set.
    always_comb begin
        busy_n = busy_q;
        if (wb_we_i && (wb_waddr_i != '0)) busy_n[wb_waddr_i] = 1'b0;
        if (branch_taken_i) begin
            for (int i = 0; i < FLUSH_CYCLES; i++) begin
                if (hist_vld_q[i]) busy_n[hist_rd_q[i]] = 1'b0;
            end
        end
        if (issue_o && id_rd_we_i && (id_rd_i != '0)) busy_n[id_rd_i] = 1'b1;
        busy_n[0] = 1'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            count_q     <= 3'd0;
            jmp_flush_q <= 1'b0;
            busy_q      <= '0;
            hist_vld_q  <= '0;
            for (int i = 0; i < FLUSH_CYCLES; i++) hist_rd_q[i] <= '0;
        end else begin
            state_q     <= state_n;
            count_q     <= count_n;
            jmp_flush_q <= issue_o & jump_i;
            busy_q      <= busy_n;
            if (branch_taken_i) begin
                hist_vld_q <= '0;
            end else begin
                for (int i = FLUSH_CYCLES - 1; i > 0; i--) begin
                    hist_vld_q[i] <= hist_vld_q[i-1];
                    hist_rd_q[i]  <= hist_rd_q[i-1];
                end
                hist_vld_q[0] <= issue_o & id_rd_we_i;
                hist_rd_q[0]  <= id_rd_i;
            end
        end
    end

    assign busy_o = busy_q;

endmodule
